id_flush_sequencer: RTL

Global-control sequencer for the instruction-ID management block. After reset it drives `gc_init_clear` for exactly one pass over all IDs. Afterwards it arbitrates flush requests from the exception, branch and system units. It drives `gc_fetch_flush`, fetch/issue holds and the fetch redirect. For exception and system flushes it waits for all issued instructions to retire before redirecting.

---
 rtl/id_flush_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/id_flush_sequencer.sv
// id_flush_sequencer: post-reset ID-table clear pass, then prioritised flush / drain / redirect control
module id_flush_sequencer #(
  parameter int MAX_IDS = 8,
  parameter int MAX_COMPLETE_COUNT = 4,
  localparam int CW = $clog2(MAX_IDS) + 1,
  localparam int RW = $clog2(MAX_COMPLETE_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exc_flush_req,
  input  logic [31:0]   exc_flush_pc,
  input  logic          br_flush_req,
  input  logic [31:0]   br_flush_pc,
  input  logic          sys_flush_req,
  input  logic [31:0]   sys_flush_pc,
  output logic          exc_flush_ack,
  output logic          br_flush_ack,
  output logic          sys_flush_ack,
  input  logic          instruction_issued,
  input  logic [RW-1:0] retire_inc,
  output logic          gc_init_clear,
  output logic          gc_fetch_flush,
  output logic          gc_fetch_hold,
  output logic          gc_issue_hold,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          init_done,
  output logic [CW-1:0] inflight_count
);
  localparam int NW = $clog2(MAX_IDS);
  typedef enum logic [2:0] {CLEAR, IDLE, FLUSH, DRAIN, REDIRECT} state_t;
  state_t r_state, w_next;
  logic [NW-1:0] r_clear_cnt;
  logic [31:0] r_pc_q;
  logic [CW-1:0] r_inflight;
  logic r_drain_q, r_init_clear, r_fetch_flush, r_fetch_hold, r_issue_hold, r_redirect_valid, r_init_done;
  logic w_clear_last, w_accept, w_drain_d;
  logic [CW:0] w_inc;
  assign w_clear_last = r_state == CLEAR && r_clear_cnt == NW'(MAX_IDS - 1);
  assign exc_flush_ack = r_state == IDLE && exc_flush_req;
  assign br_flush_ack = r_state == IDLE && br_flush_req && !exc_flush_req;
  assign sys_flush_ack = r_state == IDLE && sys_flush_req && !exc_flush_req && !br_flush_req;
  assign w_accept = exc_flush_ack || br_flush_ack || sys_flush_ack;
  assign w_drain_d = w_accept ? !br_flush_ack : r_drain_q;
  assign w_inc = (CW+1)'(r_inflight) + (CW+1)'(instruction_issued);
  assign gc_init_clear = r_init_clear;
  assign gc_fetch_flush = r_fetch_flush;
  assign gc_fetch_hold = r_fetch_hold;
  assign gc_issue_hold = r_issue_hold;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc = r_pc_q;
  assign init_done = r_init_done;
  assign inflight_count = r_inflight;
  // next-state: exception/system flushes drain outstanding work before redirecting
  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:    w_next = w_clear_last ? IDLE : CLEAR;
      IDLE:     w_next = w_accept ? FLUSH : IDLE;
      FLUSH:    w_next = r_drain_q ? DRAIN : IDLE;
      DRAIN:    w_next = r_inflight == '0 ? REDIRECT : DRAIN;
      REDIRECT: w_next = IDLE;
      default:  w_next = CLEAR;
    endcase
  end
  // state, captured request, inflight count and outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_clear_cnt <= '0;
      r_pc_q <= '0;
      r_drain_q <= 1'b0;
      r_inflight <= '0;
      r_init_clear <= 1'b1;
      r_fetch_flush <= 1'b0;
      r_fetch_hold <= 1'b1;
      r_issue_hold <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clear_cnt <= (r_state == CLEAR && !w_clear_last) ? r_clear_cnt + NW'(1) : '0;
      r_pc_q <= exc_flush_ack ? exc_flush_pc : br_flush_ack ? br_flush_pc : sys_flush_ack ? sys_flush_pc : r_pc_q;
      r_drain_q <= w_drain_d;
      r_inflight <= r_state == CLEAR ? '0 : r_inflight + CW'(instruction_issued) - CW'(retire_inc);
      r_init_clear <= w_next == CLEAR;
      r_fetch_flush <= w_next == FLUSH;
      r_fetch_hold <= w_next inside {CLEAR, FLUSH, DRAIN};
      r_issue_hold <= w_next inside {CLEAR, DRAIN} || (w_next == FLUSH && w_drain_d);
      r_redirect_valid <= w_next == REDIRECT || (w_next == FLUSH && !w_drain_d);
      r_init_done <= r_init_done || w_clear_last;
    end
  end
  a_inflight_range: assert property (@(posedge clk) disable iff (!rst)
    r_state != CLEAR |-> (w_inc >= (CW+1)'(retire_inc)) && (w_inc - (CW+1)'(retire_inc) <= (CW+1)'(MAX_IDS)));
  a_no_issue_in_drain: assert property (@(posedge clk) disable iff (!rst)
    !(r_state == DRAIN && instruction_issued));
endmodule
